// File: rtl/text_memory_arbiter_pkg.sv
// Shared constants and state encodings for the text memory arbiter.
// TEXT_BEGIN/TEXT_END mirror the text-segment bounds used by the fetch path.
package text_memory_arbiter_pkg;

  localparam logic [31:0] TEXT_BEGIN = 32'h0001_0000;
  localparam logic [31:0] TEXT_END   = 32'h0001_7FFC;
  localparam logic [31:0] OOR_WORD   = 32'h0000_0001;

  typedef enum logic [1:0] {
    TXT_ARB_IDLE = 2'd0,
    TXT_ARB_WAIT = 2'd1,
    TXT_ARB_HOLD = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_F = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  function automatic logic in_text(input logic [31:0] address);
    return (address >= TEXT_BEGIN) && (address <= TEXT_END);
  endfunction

endpackage

// File: rtl/text_arbiter_priority.sv
// Grant select between fetch (F) and data (D) ports for one grant slot.
// With TEXT_ARBITER_STARVE_GUARD_EN defined, a starvation counter forces D after STARVE_LIMIT refusals.
module text_arbiter_priority
  import text_memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic slot,
  input  logic f_valid,
  input  logic d_valid,
  output logic grant_f,
  output logic grant_d
);

`ifdef TEXT_ARBITER_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  logic       force_d;

  assign force_d = (starve_cnt >= 4'(STARVE_LIMIT));

  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (slot) begin
      if (d_valid && (!f_valid || force_d)) grant_d = 1'b1;
      else if (f_valid)                     grant_f = 1'b1;
    end
  end

  // Counter stops at the limit because D is then granted on the next contested slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             starve_cnt <= '0;
    else if (grant_d)                         starve_cnt <= '0;
    else if (slot && d_valid && !force_d)     starve_cnt <= starve_cnt + 4'd1;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset_n;

  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (slot) begin
      if (f_valid)      grant_f = 1'b1;
      else if (d_valid) grant_d = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/text_memory_arbiter.sv
// Shares the synchronous-read text memory between fetch (F) and data loads (D); one access in flight.
// Optional starvation guard for port D is enabled by defining TEXT_ARBITER_STARVE_GUARD_EN.
module text_memory_arbiter
  import text_memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        f_req_valid,
  output logic        f_req_ready,
  input  logic [31:0] f_address,
  output logic        f_rsp_valid,
  input  logic        f_rsp_ready,
  output logic [31:0] f_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_address,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rsp_data,
  output logic [13:0] mem_address,
  input  logic [31:0] mem_q
);

  arb_state_t  state, state_next;
  owner_t      owner;
  logic        in_range;
  logic [31:0] hold_q;
  logic [13:0] last_addr;
  logic [31:0] rsp_word;
  logic        owner_ready, slot, grant_f, grant_d, grant, rsp_active;

  assign owner_ready = (owner == OWNER_D) ? d_rsp_ready : f_rsp_ready;
  // Gating with reset_n keeps req_ready low while reset is held.
  assign slot = reset_n &&
                ((state == TXT_ARB_IDLE) || ((state == TXT_ARB_WAIT) && owner_ready));

  text_arbiter_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clock   (clock),
    .reset_n (reset_n),
    .slot    (slot),
    .f_valid (f_req_valid),
    .d_valid (d_req_valid),
    .grant_f (grant_f),
    .grant_d (grant_d)
  );

  assign grant       = grant_f | grant_d;
  assign f_req_ready = grant_f;
  assign d_req_ready = grant_d;
  assign mem_address = grant_d ? d_address[15:2] :
                       grant_f ? f_address[15:2] : last_addr;

  assign rsp_active  = (state == TXT_ARB_WAIT) || (state == TXT_ARB_HOLD);
  assign rsp_word    = (state == TXT_ARB_HOLD) ? hold_q : (in_range ? mem_q : OOR_WORD);
  assign f_rsp_valid = rsp_active && (owner == OWNER_F);
  assign d_rsp_valid = rsp_active && (owner == OWNER_D);
  assign f_rsp_data  = f_rsp_valid ? rsp_word : '0;
  assign d_rsp_data  = d_rsp_valid ? rsp_word : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= TXT_ARB_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TXT_ARB_IDLE: if (grant) state_next = TXT_ARB_WAIT;
      TXT_ARB_WAIT: begin
        if (owner_ready) state_next = grant ? TXT_ARB_WAIT : TXT_ARB_IDLE;
        else             state_next = TXT_ARB_HOLD;
      end
      TXT_ARB_HOLD: if (owner_ready) state_next = TXT_ARB_IDLE;
      default:      state_next = TXT_ARB_IDLE;
    endcase
  end

  // Request capture on accept; response capture when the owner stalls in WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= OWNER_F;
      in_range  <= 1'b0;
      hold_q    <= '0;
      last_addr <= '0;
    end else begin
      if (grant) begin
        owner     <= grant_d ? OWNER_D : OWNER_F;
        in_range  <= grant_d ? in_text(d_address) : in_text(f_address);
        last_addr <= mem_address;
      end
      if ((state == TXT_ARB_WAIT) && !owner_ready) hold_q <= rsp_word;
    end
  end

endmodule

// File: tb/tb_text_memory_arbiter.sv
// Self-checking bench for text_memory_arbiter: behavioural model plus directed and random stimulus.
// Model follows TEXT_ARBITER_STARVE_GUARD_EN the same way the design build does.
module tb_text_memory_arbiter;

  localparam int          LIMIT   = 4;
  localparam logic [31:0] T_BEGIN = 32'h0001_0000;
  localparam logic [31:0] T_END   = 32'h0001_7FFC;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
  logic [31:0] f_address, f_rsp_data;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
  logic [31:0] d_address, d_rsp_data;
  logic [13:0] mem_address;
  logic [31:0] mem_q = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  text_memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .f_req_valid (f_req_valid),
    .f_req_ready (f_req_ready),
    .f_address   (f_address),
    .f_rsp_valid (f_rsp_valid),
    .f_rsp_ready (f_rsp_ready),
    .f_rsp_data  (f_rsp_data),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_address   (d_address),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_ready (d_rsp_ready),
    .d_rsp_data  (d_rsp_data),
    .mem_address (mem_address),
    .mem_q       (mem_q)
  );

  function automatic logic [31:0] memword(input logic [13:0] idx);
    if (idx == 14'd2) return 32'hDEADBEEF;
    return {idx, 2'b01, idx, 2'b10} ^ 32'h5A5A_0000;
  endfunction

  // Synchronous-read memory: address seen before the edge, data after it.
  logic [13:0] addr_seen = '0;
  always @(negedge clock) addr_seen = mem_address;
  always @(posedge clock) mem_q <= memword(addr_seen);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one pending response, its age, and the expected word.
  logic        m_pend    = 1'b0;
  logic        m_owner_d = 1'b0;
  logic [31:0] m_data    = '0;
  int          m_age     = 0;
  logic [13:0] m_last    = '0;
`ifdef TEXT_ARBITER_STARVE_GUARD_EN
  int          m_starve  = 0;
`endif
  byte         grant_log[$];

  always @(negedge clock) begin
    logic        slot, gf, gd, own_rdy;
    logic [31:0] a;
    logic [13:0] exp_addr;
    if (!reset_n) begin
      check("rst_f_rsp_valid", 32'(f_rsp_valid), 32'h0);
      check("rst_d_rsp_valid", 32'(d_rsp_valid), 32'h0);
      check("rst_f_req_ready", 32'(f_req_ready), 32'h0);
      check("rst_d_req_ready", 32'(d_req_ready), 32'h0);
      check("rst_f_rsp_data", f_rsp_data, 32'h0);
      check("rst_d_rsp_data", d_rsp_data, 32'h0);
      check("rst_mem_address", 32'(mem_address), 32'h0);
      m_pend = 1'b0;
      m_last = '0;
`ifdef TEXT_ARBITER_STARVE_GUARD_EN
      m_starve = 0;
`endif
    end else begin
      own_rdy = m_owner_d ? d_rsp_ready : f_rsp_ready;
      slot    = !m_pend || (m_age == 1 && own_rdy);
      gf = 1'b0;
      gd = 1'b0;
      if (slot) begin
        if (f_req_valid && d_req_valid) begin
`ifdef TEXT_ARBITER_STARVE_GUARD_EN
          if (m_starve >= LIMIT) gd = 1'b1;
          else                   gf = 1'b1;
`else
          gf = 1'b1;
`endif
        end else begin
          gf = f_req_valid;
          gd = d_req_valid;
        end
      end
      exp_addr = gd ? d_address[15:2] : (gf ? f_address[15:2] : m_last);
      check("f_req_ready", 32'(f_req_ready), 32'(gf));
      check("d_req_ready", 32'(d_req_ready), 32'(gd));
      check("mem_address", 32'(mem_address), 32'(exp_addr));
      check("f_rsp_valid", 32'(f_rsp_valid), 32'(m_pend && !m_owner_d));
      check("d_rsp_valid", 32'(d_rsp_valid), 32'(m_pend && m_owner_d));
      if (m_pend && !m_owner_d) check("f_rsp_data", f_rsp_data, m_data);
      if (m_pend && m_owner_d)  check("d_rsp_data", d_rsp_data, m_data);

      if (m_pend && own_rdy) m_pend = 1'b0;
      else if (m_pend)       m_age++;
      if (gf || gd) begin
        grant_log.push_back(gd ? "D" : "F");
        a         = gd ? d_address : f_address;
        m_pend    = 1'b1;
        m_age     = 1;
        m_owner_d = gd;
        m_data    = (a >= T_BEGIN && a <= T_END) ? memword(a[15:2]) : 32'h0000_0001;
        m_last    = a[15:2];
      end
`ifdef TEXT_ARBITER_STARVE_GUARD_EN
      if (gd)                                          m_starve = 0;
      else if (slot && d_req_valid && m_starve < LIMIT) m_starve++;
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    f_req_valid = 1'b0; f_address = '0; f_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_address = '0; d_rsp_ready = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 3) == 0) return {r[31:17], 1'b0, r[15:0]};
    return {16'h0001, 1'b0, r[14:2], 2'b00};
  endfunction

  initial begin
    string pattern;
    logic  fs, ds;
    int    d_count;
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Single fetch to TEXT_BEGIN+8.
    f_req_valid = 1'b1; f_address = T_BEGIN + 32'd8;
    @(negedge clock);
    check("t1_f_req_ready", 32'(f_req_ready), 32'h1);
    check("t1_mem_address", 32'(mem_address), 32'h2);
    tick();
    f_req_valid = 1'b0;
    @(negedge clock);
    check("t1_f_rsp_valid", 32'(f_rsp_valid), 32'h1);
    check("t1_f_rsp_data", f_rsp_data, 32'hDEADBEEF);
    tick();

    // Data load just past TEXT_END.
    d_req_valid = 1'b1; d_address = T_END + 32'd4;
    @(negedge clock);
    check("oor_d_req_ready", 32'(d_req_ready), 32'h1);
    tick();
    d_req_valid = 1'b0;
    @(negedge clock);
    check("oor_d_rsp_valid", 32'(d_rsp_valid), 32'h1);
    check("oor_d_rsp_data", d_rsp_data, 32'h0000_0001);
    check("oor_f_rsp_valid", 32'(f_rsp_valid), 32'h0);
    tick();

    // Fetch response stalled three cycles while D waits.
    f_req_valid = 1'b1; f_address = T_BEGIN + 32'h40; f_rsp_ready = 1'b0;
    @(negedge clock);
    check("stall_accept", 32'(f_req_ready), 32'h1);
    tick();
    f_req_valid = 1'b0;
    d_req_valid = 1'b1; d_address = T_BEGIN + 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_f_rsp_data", f_rsp_data, memword(14'd16));
      check("stall_no_grant", 32'(d_req_ready), 32'h0);
      tick();
    end
    f_rsp_ready = 1'b1;
    @(negedge clock);
    check("stall_release_valid", 32'(f_rsp_valid), 32'h1);
    check("stall_release_no_grant", 32'(d_req_ready), 32'h0);
    tick();
    @(negedge clock);
    check("stall_next_grant", 32'(d_req_ready), 32'h1);
    tick();
    d_req_valid = 1'b0;
    @(negedge clock);
    check("stall_d_rsp_data", d_rsp_data, memword(14'd64));
    tick();

    // Reset while a read is in flight.
    f_req_valid = 1'b1; f_address = T_BEGIN + 32'h20;
    tick();
    f_req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    check("rstwait_f_rsp_valid", 32'(f_rsp_valid), 32'h0);
    check("rstwait_mem_address", 32'(mem_address), 32'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rstrel_f_rsp_valid", 32'(f_rsp_valid), 32'h0);
      tick();
    end
    f_req_valid = 1'b1; f_address = T_BEGIN + 32'd8;
    @(negedge clock);
    check("rstrel_accept", 32'(f_req_ready), 32'h1);
    tick();
    f_req_valid = 1'b0;
    @(negedge clock);
    check("rstrel_f_rsp_data", f_rsp_data, 32'hDEADBEEF);
    tick();

    // Both ports valid continuously, from a fresh starvation count.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    grant_log.delete();
    f_req_valid = 1'b1; f_address = T_BEGIN + 32'h80;
    d_req_valid = 1'b1; d_address = T_BEGIN + 32'hC0;
    repeat (20) tick();
    check("both_grant_count", 32'(grant_log.size()), 32'd20);
    d_count = 0;
`ifdef TEXT_ARBITER_STARVE_GUARD_EN
    pattern = "FFFFDFFFFD";
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      check("starve_pattern", 32'(grant_log[i]), 32'(pattern[i]));
`else
    pattern = "F";
    for (int i = 0; i < grant_log.size(); i++)
      if (grant_log[i] != pattern[0]) d_count++;
    check("fixed_d_never_granted", 32'(d_count), 32'h0);
`endif
    f_req_valid = 1'b0;
    @(negedge clock);
    check("f_drop_d_granted", 32'(d_req_ready), 32'h1);
    tick();
    d_req_valid = 1'b0;
    tick();

    // Randomised traffic with stalls and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      fs = f_req_valid && !f_req_ready;
      ds = d_req_valid && !d_req_ready;
      @(posedge clock);
      #1;
      reset_n = ($urandom_range(0, 499) != 0);
      if (!fs) begin f_req_valid = ($urandom_range(0, 3) != 0); f_address = rnd_addr(); end
      if (!ds) begin d_req_valid = ($urandom_range(0, 2) != 0); d_address = rnd_addr(); end
      f_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
    end

    reset_n = 1'b1;
    idle_inputs();
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
